// File: rtl/md_init_pkg.sv
// ============================================================================
//  md_init_pkg
//  Shared record geometry, cell count and loader FSM encoding.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package md_init_pkg;

   localparam int REC_WIDTH      = 96;
   localparam int REC_PER_BEAT   = 5;
   localparam int N_CELL         = 27;
   localparam int CELL_ID_WIDTH  = $clog2(N_CELL);
   localparam int SLOT_IDX_WIDTH = $clog2(REC_PER_BEAT);
   localparam int KEEP_PER_REC   = REC_WIDTH / 8;
   localparam int PAYLOAD_WIDTH  = REC_PER_BEAT * REC_WIDTH;

   // x occupies the least significant 32 bits of a record
   typedef struct packed {
      logic [31:0] z;
      logic [31:0] y;
      logic [31:0] x;
   } rec_t;

   typedef logic [1:0] state_t;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCEPT = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/h2k_slot_picker.sv
// ============================================================================
//  h2k_slot_picker
//  Lowest-set-bit priority encoder over the per-beat record slot mask.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module h2k_slot_picker
   import md_init_pkg::*;
(
   input  logic [REC_PER_BEAT-1:0]   mask,
   output logic [SLOT_IDX_WIDTH-1:0] idx,
   output logic                      any
);

   always_comb begin
      idx = '0;
      for (int k = REC_PER_BEAT - 1; k >= 0; k--) begin
         if (mask[k]) idx = k[SLOT_IDX_WIDTH-1:0];
      end
      any = |mask;
   end

endmodule

`default_nettype wire

// File: rtl/h2k_particle_loader.sv
// ============================================================================
//  h2k_particle_loader
//  Unpacks host AXI4-Stream beats into per-cell position cache writes.
//  Optional per-cell write counters: define H2K_CELL_COUNT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module h2k_particle_loader
   import md_init_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH      = 512,
   parameter int STREAMING_TDEST_WIDTH = 16,
   parameter int CNT_WIDTH             = 10
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst_n,
   input  logic [AXIS_TDATA_WIDTH-1:0]      S_AXIS_h2k_tdata,
   input  logic [AXIS_TDATA_WIDTH/8-1:0]    S_AXIS_h2k_tkeep,
   input  logic                             S_AXIS_h2k_tvalid,
   input  logic                             S_AXIS_h2k_tlast,
   input  logic [STREAMING_TDEST_WIDTH-1:0] S_AXIS_h2k_tdest,
   output logic                             S_AXIS_h2k_tready,
   input  logic                             i_load_en,
   output logic [REC_WIDTH-1:0]             o_rec_data,
   output logic [N_CELL-1:0]                o_cell_wen,
   input  logic [N_CELL-1:0]                i_cell_full,
   output logic                             o_load_done,
   output logic                             o_bad_dest,
`ifdef H2K_CELL_COUNT_EN
   output logic [N_CELL*CNT_WIDTH-1:0]      o_cell_cnt,
`endif
   output logic [15:0]                      o_total_cnt
);

   state_t                    state;
   logic                      tready;
   logic [PAYLOAD_WIDTH-1:0]  data_q;
   logic [REC_PER_BEAT-1:0]   mask;
   logic [CELL_ID_WIDTH-1:0]  dest_q;
   logic                      last_q;
   rec_t                      rec_q;
   logic [N_CELL-1:0]         cell_wen;
   logic                      load_done;
   logic                      bad_dest;
   logic [15:0]               total_cnt;

   logic [REC_PER_BEAT-1:0]   keep_ok;
   rec_t                      slot_rec [REC_PER_BEAT];
   logic [SLOT_IDX_WIDTH-1:0] pick_idx;
   logic                      pick_any;
   logic                      dest_bad;

   for (genvar k = 0; k < REC_PER_BEAT; k++) begin : g_slot
      assign keep_ok[k]  = &S_AXIS_h2k_tkeep[k*KEEP_PER_REC +: KEEP_PER_REC];
      assign slot_rec[k] = data_q[k*REC_WIDTH +: REC_WIDTH];
   end

   assign dest_bad = (S_AXIS_h2k_tdest >= STREAMING_TDEST_WIDTH'(N_CELL));

   h2k_slot_picker u_picker (
      .mask (mask),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state     <= ST_IDLE;
         tready    <= 1'b0;
         data_q    <= '0;
         mask      <= '0;
         dest_q    <= '0;
         last_q    <= 1'b0;
         rec_q     <= '0;
         cell_wen  <= '0;
         load_done <= 1'b0;
         bad_dest  <= 1'b0;
         total_cnt <= '0;
      end else begin
         cell_wen  <= '0;
         load_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_load_en) begin
                  state  <= ST_ACCEPT;
                  tready <= 1'b1;
               end
            end
            ST_ACCEPT: begin
               if (S_AXIS_h2k_tvalid) begin
                  data_q <= S_AXIS_h2k_tdata[PAYLOAD_WIDTH-1:0];
                  dest_q <= S_AXIS_h2k_tdest[CELL_ID_WIDTH-1:0];
                  last_q <= S_AXIS_h2k_tlast;
                  // out-of-range cells are swallowed but still terminate a load
                  mask   <= dest_bad ? '0 : keep_ok;
                  if (dest_bad) bad_dest <= 1'b1;
                  state  <= ST_DRAIN;
                  tready <= 1'b0;
               end else if (!i_load_en) begin
                  state  <= ST_IDLE;
                  tready <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (pick_any) begin
                  if (!i_cell_full[dest_q]) begin
                     rec_q          <= slot_rec[pick_idx];
                     cell_wen       <= N_CELL'(1) << dest_q;
                     mask[pick_idx] <= 1'b0;
                     total_cnt      <= total_cnt + 16'd1;
                  end
               end else if (last_q) begin
                  state     <= ST_DONE;
                  load_done <= 1'b1;
               end else if (i_load_en) begin
                  state  <= ST_ACCEPT;
                  tready <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign S_AXIS_h2k_tready = tready;
   assign o_rec_data        = rec_q;
   assign o_cell_wen        = cell_wen;
   assign o_load_done       = load_done;
   assign o_bad_dest        = bad_dest;
   assign o_total_cnt       = total_cnt;

`ifdef H2K_CELL_COUNT_EN
   for (genvar c = 0; c < N_CELL; c++) begin : g_cell_cnt
      logic [CNT_WIDTH-1:0] cnt;
      always_ff @(posedge ap_clk) begin
         if (!ap_rst_n || state == ST_DONE) begin
            cnt <= '0;
         end else if (cell_wen[c] && cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
      end
      assign o_cell_cnt[c*CNT_WIDTH +: CNT_WIDTH] = cnt;
   end
   logic unused_bits;
   assign unused_bits = ^{S_AXIS_h2k_tdata[AXIS_TDATA_WIDTH-1:PAYLOAD_WIDTH],
                          S_AXIS_h2k_tkeep[AXIS_TDATA_WIDTH/8-1:PAYLOAD_WIDTH/8]};
`else
   logic unused_bits;
   assign unused_bits = ^{S_AXIS_h2k_tdata[AXIS_TDATA_WIDTH-1:PAYLOAD_WIDTH],
                          S_AXIS_h2k_tkeep[AXIS_TDATA_WIDTH/8-1:PAYLOAD_WIDTH/8],
                          1'(CNT_WIDTH)};
`endif

endmodule

`default_nettype wire
